// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Byte-stream program loader. Accepts a length-prefixed image from a host byte
// source and writes it word by word into the core's instruction memory. The
// core is held in reset until a complete image has been accepted.
//
// Stream: N[15:8], N[7:0], then N words of 4 bytes each (MSB first), then
// (checksum build only) one byte equal to the XOR of all 4N payload bytes.
//
// Optional feature macro: PROG_LOADER_CSUM_EN
//   defined   - a trailing checksum byte is expected; a mismatch goes to ERR.
//   undefined - no checksum byte and no CSUM state; ERR only on length overflow.
//
// Parameters:
//   AW          instruction-memory word-address width (capacity 2^AW words)
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   start       single-cycle load request (honoured in IDLE, DONE, ERR)
//   byte_valid  host byte available
//   byte_data   host byte
//   byte_ready  loader accepts a byte this cycle
//   imem_we     instruction-memory write strobe, one cycle per word
//   imem_addr   word address for the write
//   imem_wd     word to write
//   core_reset  active-high reset to the core (low only in DONE)
//   done        image loaded and accepted
//   error       load rejected
// -----------------------------------------------------------------------------
module prog_loader #(
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wd,
    output logic          core_reset,
    output logic          done,
    output logic          error
);

    // Largest legal word count; 17 bits so 2^AW itself is representable.
    localparam logic [16:0] CAPACITY = 17'd1 << AW;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
`ifdef PROG_LOADER_CSUM_EN
        CSUM   = 3'd4,
`endif
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

    // Where the stream goes once the payload is exhausted.
`ifdef PROG_LOADER_CSUM_EN
    localparam state_t AFTER_DATA = CSUM;
`else
    localparam state_t AFTER_DATA = DONE;
`endif

    state_t        state;
    state_t        state_next;
    logic          xfer;
    logic [15:0]   len;
    logic [16:0]   len_full;
    logic [AW:0]   word_idx;      // AW+1 bits so N = 2^AW can be counted
    logic [1:0]    byte_cnt;
    logic [23:0]   asm_q;         // first three bytes of the word in flight
    logic          word_last;
`ifdef PROG_LOADER_CSUM_EN
    logic [7:0]    csum;
`endif

    assign xfer      = byte_valid & byte_ready;
    // Complete length as seen on the edge that accepts N[7:0].
    assign len_full  = {1'b0, len[15:8], byte_data};
    assign word_last = (17'(word_idx) + 17'd1) == {1'b0, len};

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: default assignment first so every path drives state_next and
        // no latch is inferred.
        state_next = state;
        case (state)
            IDLE:   if (start) state_next = LEN_HI;
            LEN_HI: if (xfer)  state_next = LEN_LO;
            LEN_LO: begin
                if (xfer) begin
                    if (len_full > CAPACITY)    state_next = ERR;
                    else if (len_full == 17'd0) state_next = AFTER_DATA;
                    else                        state_next = DATA;
                end
            end
            DATA: begin
                if (xfer && byte_cnt == 2'd3 && word_last) state_next = AFTER_DATA;
            end
`ifdef PROG_LOADER_CSUM_EN
            CSUM: begin
                if (xfer) state_next = (byte_data == csum) ? DONE : ERR;
            end
`endif
            DONE, ERR: if (start) state_next = LEN_HI;
            default:   state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // State register and status outputs. Outputs are registered decodes of
    // the next state, so they change exactly with the state and never glitch.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!reset) begin
            state      <= IDLE;
            byte_ready <= 1'b0;
            core_reset <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= state_next;
            byte_ready <= !(state_next inside {IDLE, DONE, ERR});
            core_reset <= (state_next != DONE);
            done       <= (state_next == DONE);
            error      <= (state_next == ERR);
        end
    end

    // ------------------------------------------------------------------------
    // Datapath: length capture, word assembly, write strobe, checksum.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: only this block's registers are reset; the instruction memory
        // itself is never cleared, so an aborted load leaves a partial image.
        if (!reset) begin
            len       <= '0;
            word_idx  <= '0;
            byte_cnt  <= '0;
            asm_q     <= '0;
            imem_we   <= 1'b0;
            imem_addr <= '0;
            imem_wd   <= '0;
`ifdef PROG_LOADER_CSUM_EN
            csum      <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        word_idx <= '0;
                        byte_cnt <= '0;
`ifdef PROG_LOADER_CSUM_EN
                        csum     <= '0;
`endif
                    end
                end
                LEN_HI: if (xfer) len[15:8] <= byte_data;
                LEN_LO: if (xfer) len[7:0]  <= byte_data;
                DATA: begin
                    if (xfer) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        asm_q    <= {asm_q[15:0], byte_data};
`ifdef PROG_LOADER_CSUM_EN
                        csum     <= csum ^ byte_data;
`endif
                        if (byte_cnt == 2'd3) begin
                            imem_we   <= 1'b1;
                            imem_addr <= word_idx[AW-1:0];
                            imem_wd   <= {asm_q, byte_data};
                            word_idx  <= word_idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
//
// Directed self-checking bench for prog_loader (AW = 6). Streams are built
// per test; the checksum byte is appended only when PROG_LOADER_CSUM_EN is
// defined, so the same bench serves both builds. Inputs change on the falling
// edge, outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_prog_loader;

    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wd;
    logic          core_reset;
    logic          done;
    logic          error;

    always #5 clk = ~clk;

    prog_loader #(.AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wd    (imem_wd),
        .core_reset (core_reset),
        .done       (done),
        .error      (error)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   wd;
    } wr_t;

    wr_t        wr_q[$];
    wr_t        exp_q[$];
    logic [7:0] stream[$];
    int         we_double;
    logic       we_prev;
    int         n_checks;
    int         n_pass;

    // Write monitor: records every strobe and flags any strobe lasting two cycles.
    always @(negedge clk) begin
        if (imem_we) begin
            wr_q.push_back(wr_t'{addr: imem_addr, wd: imem_wd});
            if (we_prev) we_double++;
        end
        we_prev = imem_we;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents one byte and returns on the falling edge after it was taken.
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        byte_data  = b;
        byte_valid = 1'b1;
        while (!byte_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!byte_ready) begin
            check("ready_timeout", 32'(byte_ready), 32'd1);
            byte_valid = 1'b0;
            return;
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    // gapped = 1 inserts 0/1/2 idle cycles between bytes in rotation.
    task automatic send_range(input int lo, input int hi, input bit gapped);
        for (int i = lo; i <= hi; i++) begin
            send_byte(stream[i]);
            if (gapped && i != hi) repeat (i % 3) @(negedge clk);
        end
    endtask

    task automatic send_all(input bit gapped);
        send_range(0, stream.size() - 1, gapped);
    endtask

    task automatic check_writes(input string tag);
        @(negedge clk);
        check({tag, "_count"}, 32'(wr_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < wr_q.size()) begin
                check({tag, "_addr"}, 32'(wr_q[i].addr), 32'(exp_q[i].addr));
                check({tag, "_data"}, wr_q[i].wd, exp_q[i].wd);
            end
        end
    endtask

    task automatic check_status(input string tag, input logic d, input logic e,
                                input logic cr, input logic rdy);
        check({tag, "_done"},       32'(done),       32'(d));
        check({tag, "_error"},      32'(error),      32'(e));
        check({tag, "_core_reset"}, 32'(core_reset), 32'(cr));
        check({tag, "_byte_ready"}, 32'(byte_ready), 32'(rdy));
    endtask

    task automatic check_reset_values(input string tag);
        check_status(tag, 1'b0, 1'b0, 1'b1, 1'b0);
        check({tag, "_we"},   32'(imem_we),   32'd0);
        check({tag, "_addr"}, 32'(imem_addr), 32'd0);
        check({tag, "_wd"},   imem_wd,        32'd0);
    endtask

    // Two-word image; the XOR of its eight payload bytes is 0x85.
    task automatic set_normal();
        stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h04, 8'h00, 8'h00};
        exp_q  = '{wr_t'{addr: 6'd0, wd: 32'h2008_0005}, wr_t'{addr: 6'd1, wd: 32'hAC04_0000}};
    endtask

    initial begin
        logic [7:0]  x;
        logic [31:0] w;

        reset      = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        n_checks   = 0;
        n_pass     = 0;
        we_double  = 0;
        we_prev    = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'(byte_ready), 32'd0);

        // Normal load, back-to-back bytes
        wr_q.delete();
        pulse_start();
        check_status("start", 1'b0, 1'b0, 1'b1, 1'b1);
        set_normal();
`ifdef PROG_LOADER_CSUM_EN
        stream.push_back(8'h85);
`endif
        send_all(1'b0);
        check_status("normal", 1'b1, 1'b0, 1'b0, 1'b0);
        check_writes("normal");

`ifdef PROG_LOADER_CSUM_EN
        // Bad checksum, started from DONE
        wr_q.delete();
        pulse_start();
        check_status("restart_done", 1'b0, 1'b0, 1'b1, 1'b1);
        set_normal();
        stream.push_back(8'h22);
        send_all(1'b0);
        check_status("badcsum", 1'b0, 1'b1, 1'b1, 1'b0);
        check_writes("badcsum");
`endif

        // Empty image: N = 0 (restart from DONE in the default build)
        wr_q.delete();
        exp_q.delete();
        pulse_start();
        check_status("restart_empty", 1'b0, 1'b0, 1'b1, 1'b1);
        stream = '{8'h00, 8'h00};
`ifdef PROG_LOADER_CSUM_EN
        stream.push_back(8'h00);
`endif
        send_all(1'b0);
        check_status("empty", 1'b1, 1'b0, 1'b0, 1'b0);
        check_writes("empty");

        // Full memory: N = 0x0040, last write to address 63
        wr_q.delete();
        exp_q.delete();
        stream = '{8'h00, 8'h40};
        x = 8'h00;
        for (int i = 0; i < 64; i++) begin
            w = {8'(i), 8'hC3, ~8'(i), 8'(i * 5)};
            exp_q.push_back(wr_t'{addr: 6'(i), wd: w});
            for (int b = 3; b >= 0; b--) begin
                stream.push_back(w[b*8 +: 8]);
                x = x ^ w[b*8 +: 8];
            end
        end
`ifdef PROG_LOADER_CSUM_EN
        stream.push_back(x);
`endif
        pulse_start();
        send_all(1'b0);
        check_status("full", 1'b1, 1'b0, 1'b0, 1'b0);
        check_writes("full");

        // Overflow: N = 0x0041 rejected right after the second length byte
        wr_q.delete();
        exp_q.delete();
        pulse_start();
        stream = '{8'h00, 8'h41};
        send_all(1'b0);
        check_status("overflow", 1'b0, 1'b1, 1'b1, 1'b0);
        check_writes("overflow");

        // Flow control: gaps in byte_valid, started from ERR
        wr_q.delete();
        we_double = 0;
        pulse_start();
        set_normal();
`ifdef PROG_LOADER_CSUM_EN
        stream.push_back(8'h85);
`endif
        send_all(1'b1);
        check_status("gapped", 1'b1, 1'b0, 1'b0, 1'b0);
        check_writes("gapped");
        check("we_single_cycle", 32'(we_double), 32'd0);

        // Reset after 5 payload bytes (word 0 already written)
        pulse_start();
        set_normal();
        send_range(0, 6, 1'b0);
        reset = 1'b0;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        wr_q.delete();
        pulse_start();
        set_normal();
`ifdef PROG_LOADER_CSUM_EN
        stream.push_back(8'h85);
`endif
        send_all(1'b0);
        check_status("after_rst", 1'b1, 1'b0, 1'b0, 1'b0);
        check_writes("after_rst");

        // start during DATA is ignored and clears nothing
        wr_q.delete();
        pulse_start();
        set_normal();
`ifdef PROG_LOADER_CSUM_EN
        stream.push_back(8'h85);
`endif
        send_range(0, 3, 1'b0);
        pulse_start();
        check("data_start_ready", 32'(byte_ready), 32'd1);
        send_range(4, stream.size() - 1, 1'b0);
        check_status("data_start", 1'b1, 1'b0, 1'b0, 1'b0);
        check_writes("data_start");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
